// File: rtl/bcd_counter_seg7_scan.sv
`default_nettype none
// ============================================================================
// Module   : bcd_counter_seg7_scan
// Purpose  : Multi-digit BCD up/down counter with load and wrap-carry, driving
//            a time-multiplexed common-anode seven-segment display.
// Ports    : clk       - system clock
//            rst_n     - asynchronous active-low reset
//            en        - count enable (gates prescaler and stepping)
//            up_dn     - 1 = increment, 0 = decrement (sampled on tick)
//            load      - synchronous load strobe (priority over tick)
//            load_val  - BCD load value, nibble i = digit i (nibbles >9 -> 9)
//            count     - current BCD value
//            carry     - one-cycle pulse after a wrapping step
//            seg       - {g,f,e,d,c,b,a}, active-low
//            an        - one-hot active-low digit enables
// Options  : SEG7_LEADING_ZERO_BLANK_EN - blank leading zero digits (k>0)
// Revision : 1.0 - initial release
// ============================================================================
module bcd_counter_seg7_scan #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 12000000,
  parameter int SCAN_DIV = 12000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                up_dn,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                carry,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   an
);

  localparam int c_pw = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int c_sw = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_iw = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;

  localparam logic [c_pw-1:0]   c_presc_last = c_pw'(PRESCALE - 1);
  localparam logic [c_sw-1:0]   c_scan_last  = c_sw'(SCAN_DIV - 1);
  localparam logic [c_iw-1:0]   c_idx_last   = c_iw'(DIGITS - 1);
  localparam logic [DIGITS-1:0] c_an_reset   = ~DIGITS'(1);
  localparam logic [6:0]        c_glyph_zero = 7'b1000000;

  function automatic logic [6:0] seg7_glyph(input logic [3:0] d);
    case (d)
      4'd0:    seg7_glyph = 7'b1000000;
      4'd1:    seg7_glyph = 7'b1111001;
      4'd2:    seg7_glyph = 7'b0100100;
      4'd3:    seg7_glyph = 7'b0110000;
      4'd4:    seg7_glyph = 7'b0011001;
      4'd5:    seg7_glyph = 7'b0010010;
      4'd6:    seg7_glyph = 7'b0000010;
      4'd7:    seg7_glyph = 7'b1111000;
      4'd8:    seg7_glyph = 7'b0000000;
      4'd9:    seg7_glyph = 7'b0010000;
      default: seg7_glyph = 7'b1111111;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Counter datapath
  // --------------------------------------------------------------------------
  logic [4*DIGITS-1:0] r_count;
  logic [c_pw-1:0]     r_presc;
  logic                r_carry;

  logic                w_tick;
  logic [4*DIGITS-1:0] w_step;
  logic [4*DIGITS-1:0] w_load_clamped;
  logic                w_ripple;
  logic                w_wrap;
  logic [3:0]          w_dig;

  assign w_tick = en && (r_presc == c_presc_last);

  // Ripple +1/-1 from the LSD. w_ripple carries the pending carry (up) or
  // borrow (down) into the next digit; if it survives past the MSD the whole
  // counter has wrapped.
  always_comb begin
    w_step   = r_count;
    w_ripple = 1'b1;
    w_dig    = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      w_dig = r_count[4*k +: 4];
      if (w_ripple) begin
        if (up_dn) begin
          if (w_dig >= 4'd9) begin
            w_step[4*k +: 4] = 4'd0;
          end else begin
            w_step[4*k +: 4] = w_dig + 4'd1;
            w_ripple         = 1'b0;
          end
        end else begin
          if (w_dig == 4'd0) begin
            w_step[4*k +: 4] = 4'd9;
          end else begin
            w_step[4*k +: 4] = w_dig - 4'd1;
            w_ripple         = 1'b0;
          end
        end
      end
    end
    w_wrap = w_ripple;
  end

  always_comb begin
    w_load_clamped = load_val;
    for (int k = 0; k < DIGITS; k++) begin
      if (load_val[4*k +: 4] > 4'd9) w_load_clamped[4*k +: 4] = 4'd9;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_presc <= '0;
      r_carry <= 1'b0;
    end else begin
      r_carry <= 1'b0;
      if (load) begin
        // Load wins over a coincident tick: no step, no carry.
        r_count <= w_load_clamped;
        r_presc <= '0;
      end else begin
        if (en) r_presc <= w_tick ? '0 : r_presc + c_pw'(1);
        if (w_tick) begin
          r_count <= w_step;
          r_carry <= w_wrap;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Display scanner (free-running)
  // --------------------------------------------------------------------------
  logic [c_sw-1:0]   r_scan_div;
  logic [c_iw-1:0]   r_idx;
  logic [DIGITS-1:0] r_an;
  logic [6:0]        r_seg;

  logic              w_scan_tc;
  logic [c_iw-1:0]   w_idx_nxt;
  logic [3:0]        w_nib;
  logic [DIGITS-1:0] w_an_nxt;
  logic [6:0]        w_seg_nxt;

  assign w_scan_tc = (r_scan_div == c_scan_last);
  assign w_idx_nxt = !w_scan_tc              ? r_idx :
                     (r_idx == c_idx_last)   ? '0    : r_idx + c_iw'(1);

  // an and seg are both derived from the next index so they move together.
  always_comb begin
    w_nib    = 4'd0;
    w_an_nxt = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (w_idx_nxt == c_iw'(k)) begin
        w_nib       = r_count[4*k +: 4];
        w_an_nxt[k] = 1'b0;
      end
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic w_zero_run;
  logic w_blank;

  // Walk from the MSD down: a digit is a leading zero while every nibble from
  // the MSD to it is zero. Digit 0 always shows.
  always_comb begin
    w_zero_run = 1'b1;
    w_blank    = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_zero_run = w_zero_run && (r_count[4*k +: 4] == 4'd0);
      if ((k > 0) && w_zero_run && (w_idx_nxt == c_iw'(k))) w_blank = 1'b1;
    end
  end

  assign w_seg_nxt = w_blank ? 7'b1111111 : seg7_glyph(w_nib);
`else
  assign w_seg_nxt = seg7_glyph(w_nib);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_div <= '0;
      r_idx      <= '0;
      r_an       <= c_an_reset;
      r_seg      <= c_glyph_zero;
    end else begin
      r_scan_div <= w_scan_tc ? '0 : r_scan_div + c_sw'(1);
      r_idx      <= w_idx_nxt;
      r_an       <= w_an_nxt;
      r_seg      <= w_seg_nxt;
    end
  end

  assign count = r_count;
  assign carry = r_carry;
  assign seg   = r_seg;
  assign an    = r_an;

endmodule
`default_nettype wire

// File: tb/tb_bcd_counter_seg7_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_counter_seg7_scan
// Purpose  : Self-checking bench for bcd_counter_seg7_scan (DIGITS=2,
//            PRESCALE=4, SCAN_DIV=2). Expected count steps are queued with
//            the clock cycle they must appear on; a monitor compares every
//            count change against the queue and checks carry is idle
//            otherwise. Honors SEG7_LEADING_ZERO_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_counter_seg7_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       carry;
  logic [6:0] seg;
  logic [1:0] an;

  bcd_counter_seg7_scan #(
    .DIGITS  (2),
    .PRESCALE(4),
    .SCAN_DIV(2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .up_dn   (up_dn),
    .load    (load),
    .load_val(load_val),
    .count   (count),
    .carry   (carry),
    .seg     (seg),
    .an      (an)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned at;
    logic [7:0]  cnt;
    logic        cy;
  } exp_t;

  exp_t       q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] last_cnt = 8'h00;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic expect_step(input int unsigned at, input logic [7:0] v, input logic cy);
    q.push_back('{at, v, cy});
  endtask

  task automatic do_load(input logic [7:0] v, input logic [7:0] want);
    load     = 1'b1;
    load_val = v;
    expect_step(cyc + 1, want, 1'b0);
    tick(1);
    load = 1'b0;
  endtask

  task automatic mon_sample();
    exp_t e;
    if (!rst_n) begin
      last_cnt = count;
    end else if (count !== last_cnt) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL step: count=%h appeared at cycle %0d with nothing expected", count, cyc);
      end else begin
        e = q.pop_front();
        if (count !== e.cnt || carry !== e.cy || cyc != e.at) begin
          n_err++;
          $display("FAIL step: got count=%h carry=%b cycle=%0d, want count=%h carry=%b cycle=%0d",
                   count, carry, cyc, e.cnt, e.cy, e.at);
        end
      end
      last_cnt = count;
    end else begin
      check("carry_idle", {7'b0, carry}, 8'h00);
    end
  endtask

  task automatic scan_check(input logic [6:0] seg_msd, input logic [6:0] seg_lsd, input string tag);
    logic [1:0] an_s[8];
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      an_s[i] = an;
      if (an == 2'b10)      check({tag, "_seg_lsd"}, {1'b0, seg}, {1'b0, seg_lsd});
      else if (an == 2'b01) check({tag, "_seg_msd"}, {1'b0, seg}, {1'b0, seg_msd});
      else                  check({tag, "_an_onehot"}, {6'b0, an}, 8'h02);
    end
    for (int i = 0; i < 6; i++) check({tag, "_an_toggle"}, {6'b0, an_s[i+2]}, {6'b0, ~an_s[i]});
    tick(1);
  endtask

  task automatic stimulus();
    logic [6:0] seg_lz;
    rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 8'h00;
    tick(1);
    check("rst_count", count, 8'h00);
    check("rst_carry", {7'b0, carry}, 8'h00);
    check("rst_an", {6'b0, an}, 8'h02);
    check("rst_seg", {1'b0, seg}, {1'b0, 7'b1000000});
    tick(1);
    rst_n = 1'b1;

    // Up wrap 98 -> 99 -> 00 (carry) -> 01
    do_load(8'h98, 8'h98);
    en = 1'b1; up_dn = 1'b1;
    expect_step(cyc + 4,  8'h99, 1'b0);
    expect_step(cyc + 8,  8'h00, 1'b1);
    expect_step(cyc + 12, 8'h01, 1'b0);
    tick(12); en = 1'b0;

    // Down wrap 00 -> 99 (carry) -> 98
    do_load(8'h00, 8'h00);
    en = 1'b1; up_dn = 1'b0;
    expect_step(cyc + 4, 8'h99, 1'b1);
    expect_step(cyc + 8, 8'h98, 1'b0);
    tick(8); en = 1'b0;

    // Borrow across digits 10 -> 09
    do_load(8'h10, 8'h10);
    en = 1'b1; up_dn = 1'b0;
    expect_step(cyc + 4, 8'h09, 1'b0);
    tick(4); en = 1'b0;

    // Clamp 3F -> 39
    do_load(8'h3F, 8'h39);

    // Load coincident with a tick: load wins, prescaler restarts
    en = 1'b1; up_dn = 1'b1;
    expect_step(cyc + 4, 8'h50, 1'b0);
    expect_step(cyc + 8, 8'h51, 1'b0);
    tick(3);
    load = 1'b1; load_val = 8'h50;
    tick(1);
    load = 1'b0;
    up_dn = 1'b0;   // flipped between ticks, restored before the tick cycle
    tick(2);
    up_dn = 1'b1;
    tick(2); en = 1'b0;

    // Enable hold at prescaler=2
    do_load(8'h20, 8'h20);
    en = 1'b1; up_dn = 1'b1;
    tick(2);
    en = 1'b0;
    tick(10);
    en = 1'b1;
    expect_step(cyc + 2, 8'h21, 1'b0);
    tick(2); en = 1'b0;

    // Scan 25
    do_load(8'h25, 8'h25);
    tick(1);
    scan_check(7'b0100100, 7'b0010010, "scan25");

    // Leading zero on 05
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    seg_lz = 7'b1111111;
`else
    seg_lz = 7'b1000000;
`endif
    do_load(8'h05, 8'h05);
    tick(1);
    scan_check(seg_lz, 7'b0010010, "scan05");

    // Mid-operation reset
    en = 1'b1; up_dn = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_count", count, 8'h00);
    check("mid_rst_carry", {7'b0, carry}, 8'h00);
    check("mid_rst_an", {6'b0, an}, 8'h02);
    check("mid_rst_seg", {1'b0, seg}, {1'b0, 7'b1000000});
    tick(1);
    rst_n = 1'b1;
    expect_step(cyc + 4, 8'h01, 1'b0);
    tick(4); en = 1'b0;
    tick(3);
    check("queue_empty", 8'(q.size()), 8'd0);
  endtask

  initial begin
    fork
      begin
        forever begin
          @(negedge clk);
          mon_sample();
        end
      end
      begin
        stimulus();
      end
      begin
        #200000;
        n_err++;
        $display("FAIL watchdog: time limit reached, got no end of stimulus, want completion");
      end
    join_any
    disable fork;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_counter_seg7_scan.md
Name: bcd_counter_seg7_scan

Overview:
- Parametrised multi-digit BCD up/down counter driving a time-multiplexed, common-anode seven-segment display.
- Generalises the team's combinational increment-and-display decoder into a clocked block with:
  - configurable digit count, tick rate and scan rate
  - direction, load and wrap-carry
- Sits between board switches/buttons and the display pins on the FPGA top level.

Parameters:
- DIGITS, 4: number of BCD digits; counter width 4*DIGITS.
- PRESCALE, 12000000: clk cycles per count tick (≥2).
- SCAN_DIV, 12000: clk cycles each digit stays active during scanning (≥1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  count enable; gates prescaler and stepping.
- up_dn  in  1  1 = increment, 0 = decrement.
- load  in  1  synchronous load strobe.
- load_val  in  4*DIGITS  BCD load value; nibble i = digit i, digit 0 = LSD.
- count  out  4*DIGITS  current BCD value.
- carry  out  1  one-cycle pulse on wrap.
- seg  out  7  {g,f,e,d,c,b,a}, active-low (0 = lit).
- an  out  DIGITS  digit enables, active-low, one-hot.

Behaviour:
- Reset (async assert, sync release): count=0, prescaler=0, carry=0, scan index=0, scan divider=0, an={DIGITS-1{1},0}, seg=7'b1000000 (glyph 0).
- Prescaler:
  - When en=1: counts 0..PRESCALE-1, then wraps to 0; tick asserts in the cycle it equals PRESCALE-1.
  - When en=0: holds its value; no tick.
- Step on tick: count updates at the clock edge ending the tick cycle.
  - Up: digit 0 +1. A digit at 9 becomes 0 and propagates +1 to the next digit.
  - Down: digit 0 -1. A digit at 0 becomes 9 and propagates a borrow.
- Wrap:
  - Up from all-9s gives all-0s; down from all-0s gives all-9s.
  - carry=1 for exactly the one cycle following the wrapping edge; otherwise 0.
- Load:
  - load=1 sets count=load_val on the next edge and clears the prescaler to 0, regardless of en.
  - Any nibble >9 is stored as 9.
  - Load has priority over a coincident tick: no step, no carry.
- up_dn is sampled only in tick cycles; changing it between ticks has no effect on the pending step.
- Scanner:
  - Free-running, independent of en and load.
  - Divider counts 0..SCAN_DIV-1. At terminal count the scan index advances (DIGITS-1 wraps to 0).
  - an and seg are registered together from the new index and the current count, so they always change on the same edge.
  - an[k]=0 only for the active index k.
- Segment encoding (active-low {g..a}): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Mid-operation reset: all state returns to reset values immediately; no carry pulse is produced.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: a digit k>0 whose nibble is 0, with every more-significant nibble also 0, drives seg=7'b1111111 (blank) while active. Digit 0 is never blanked. an scanning is unchanged.
- Undefined: all digits are always displayed, including leading zeros.

Test Plan:
- Bench parameters: DIGITS=2, PRESCALE=4, SCAN_DIV=2, macro undefined unless stated.
- Reset: assert rst_n=0 mid-simulation -> count=8'h00, carry=0, an=2'b10, seg=7'b1000000, all immediately.
- Up wrap: load 8'h98, then en=1 and up_dn=1 -> count 8'h99 after 4 cycles, 8'h00 after 8. carry high exactly one cycle after the second step; 8'h99 never re-appears.
- Down wrap: load 8'h00, en=1, up_dn=0 -> count 8'h99 after 4 cycles, one carry pulse. Next step gives 8'h98; 8'h10 steps to 8'h09.
- Load clamp and priority:
  - load 8'h3F -> count 8'h39.
  - Assert load=1 with load_val=8'h50 in a tick cycle -> count 8'h50, no carry, next step 4 cycles later.
- Enable hold: en=0 for 10 cycles at prescaler=2 -> count frozen. After en=1, next step occurs 2 cycles later.
- Scan: count 8'h25 -> an toggles 10/01 every 2 cycles; seg=0010010 with an=10, seg=0100100 with an=01.
  - With SEG7_LEADING_ZERO_BLANK_EN and count 8'h05: the an=01 slot shows seg=1111111.
